instruction_fetch: RTL and testbench

Front-end fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives it onto the memory's `pc` input. It captures the returned `instruction_code` together with its PC into a small prefetch queue, and presents instructions to decode through a valid/ready handshake. It also accepts redirects from branch/JALR resolution and stops cleanly at the end of the byte-addressed instruction store.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/instruction_fetch_if.sv | 22 ++
 rtl/fetch_queue.sv | 55 +++++
 rtl/instruction_fetch.sv | 92 +++++++++
 tb/tb_instruction_fetch.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end: instruction size,
// default reset PC, fetch FSM encoding and PC alignment helper.
package fetch_pkg;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-to-decode handshake plus the redirect request from branch/JALR resolution.
interface instruction_fetch_if;
    // A head entry transfers on every rising edge where if_valid && if_ready.
    // While if_valid=1 and if_ready=0, if_instr/if_pc hold their values.
    // redirect_valid is a single-cycle request with no back-pressure.
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output if_valid, if_instr, if_pc,
        input  if_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  if_valid, if_instr, if_pc,
        output if_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Shift-register prefetch FIFO: slot 0 is always the head, so the head fields
// come straight from flops. Supports simultaneous push/pop and a flush.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] slot [DEPTH];
    logic [CW-1:0]    count;
    logic [CW-1:0]    wr_idx;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = slot[0];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // A pop shifts everything down one slot, so the write lands one lower.
    assign wr_idx  = do_pop ? (count - CW'(1)) : count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    slot[i] <= slot[i+1];
                end
            end
            if (do_push) begin
                slot[wr_idx] <= push_data;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, pushes {pc, instruction_code} into the prefetch
// queue, handles redirects and halts at the end of instruction memory.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int          MEM_BYTES = 112,
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          DEPTH     = 2
) (
    input  logic                clk,
    input  logic                reset,
    output logic [31:0]         pc,
    input  logic [31:0]         instruction_code,
    instruction_fetch_if.master fetch_bus,
    output logic                fetch_done,
    output logic                misalign_err,
    output fetch_state_e        state_dbg
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
    localparam logic [31:0] LAST_PC   = 32'(MEM_BYTES - INSTR_BYTES);
    localparam logic [31:0] STEP      = 32'(INSTR_BYTES);

    fetch_state_e state, state_next;
    logic [31:0]  pc_next;
    logic [31:0]  target;
    logic         misalign_next;
    logic         pop;
    logic         push;
    logic         q_full;
    logic         q_empty;
    logic [63:0]  q_head;

    assign target = align_pc(fetch_bus.redirect_pc);
    assign pop    = fetch_bus.if_valid && fetch_bus.if_ready;
    // A redirect owns the cycle: nothing from the old stream may enter the queue.
    assign push   = (state == RUN) && (!q_full || pop) && !fetch_bus.redirect_valid;

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (fetch_bus.redirect_valid),
        .push      (push),
        .pop       (pop),
        .push_data ({pc, instruction_code}),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign fetch_bus.if_valid = !q_empty;
    assign fetch_bus.if_pc    = q_head[63:32];
    assign fetch_bus.if_instr = q_head[31:0];
    assign fetch_done         = (state == HALT) && q_empty;
    assign state_dbg          = state;

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        misalign_next = misalign_err;
        if (fetch_bus.redirect_valid) begin
            // Out-of-range targets park the PC there without ever fetching it.
            pc_next    = target;
            state_next = (target < MEM_LIMIT) ? RUN : HALT;
            if (fetch_bus.redirect_pc[1:0] != 2'b00) begin
                misalign_next = 1'b1;
            end
        end else if (push) begin
            if (pc == LAST_PC) begin
                state_next = HALT;
            end else begin
                pc_next = pc + STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            misalign_err <= misalign_next;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a
// randomized run scored against a queue-based reference model.
module tb_instruction_fetch;
    import fetch_pkg::*;

    localparam int          MEM_BYTES = 112;
    localparam int          DEPTH     = 2;
    localparam int          N_WORDS   = MEM_BYTES / 4;
    localparam logic [31:0] W0        = 32'h0020_81B3;
    localparam logic [31:0] W1        = 32'h0020_91B3;
    localparam logic [31:0] W2        = 32'h0020_A1B3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  pc;
    logic [31:0]  instruction_code;
    logic         fetch_done;
    logic         misalign_err;
    fetch_state_e state_dbg;

    logic [31:0]  imem [N_WORDS];
    logic [63:0]  exp_q[$];
    int           n_cmp = 0;
    int           n_fail = 0;

    instruction_fetch_if fetch_bus();

    instruction_fetch #(
        .MEM_BYTES (MEM_BYTES),
        .RESET_PC  (32'h0),
        .DEPTH     (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pc               (pc),
        .instruction_code (instruction_code),
        .fetch_bus        (fetch_bus.master),
        .fetch_done       (fetch_done),
        .misalign_err     (misalign_err),
        .state_dbg        (state_dbg)
    );

    // Clock / combinational instruction memory
    always #5 clk = ~clk;
    assign instruction_code = (pc < 32'(MEM_BYTES)) ? imem[pc[6:2]] : 32'h0;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
        fetch_bus.if_ready       = rdy;
        fetch_bus.redirect_valid = rv;
        fetch_bus.redirect_pc    = rpc;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset();
        logic [99:0] got;
        logic [99:0] exp;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        got = {pc, fetch_bus.if_valid, fetch_bus.if_instr, fetch_bus.if_pc, fetch_done, misalign_err, state_dbg};
        exp = {32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, RUN};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", got, exp);
        end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] words [3];
        words[0] = W0; words[1] = W1; words[2] = W2;
        apply_reset();
        drive(1'b1, 1'b0, 32'h0);
        n_cmp++;
        if ({pc, fetch_bus.if_valid} !== {32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL first_cycle: pc %h valid %b expected pc 0 valid 0", pc, fetch_bus.if_valid);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if ({fetch_bus.if_valid, fetch_bus.if_pc, fetch_bus.if_instr, fetch_done} !== {1'b1, 32'(k * 4), words[k], 1'b0}) begin
                n_fail++;
                $display("FAIL stream_beat%0d: valid %b pc %h instr %h done %b expected 1 %h %h 0",
                         k, fetch_bus.if_valid, fetch_bus.if_pc, fetch_bus.if_instr, fetch_done, 32'(k * 4), words[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] words [3];
        words[0] = W0; words[1] = W1; words[2] = W2;
        apply_reset();
        drive(1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if ({fetch_bus.if_valid, fetch_bus.if_pc, fetch_bus.if_instr} !== {1'b1, 32'h0, W0}) begin
                n_fail++;
                $display("FAIL bp_head_hold%0d: valid %b pc %h instr %h expected 1 0 %h",
                         c, fetch_bus.if_valid, fetch_bus.if_pc, fetch_bus.if_instr, W0);
            end
        end
        n_cmp++;
        if (pc !== 32'h8) begin
            n_fail++;
            $display("FAIL bp_pc_stall: got %h expected 00000008", pc);
        end
        drive(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({fetch_bus.if_valid, fetch_bus.if_pc, fetch_bus.if_instr} !== {1'b1, 32'(k * 4), words[k]}) begin
                n_fail++;
                $display("FAIL bp_drain%0d: valid %b pc %h instr %h expected 1 %h %h",
                         k, fetch_bus.if_valid, fetch_bus.if_pc, fetch_bus.if_instr, 32'(k * 4), words[k]);
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        drive(1'b0, 1'b0, 32'h0);
        repeat (3) tick();
        drive(1'b1, 1'b1, 32'h20);
        tick();
        drive(1'b1, 1'b0, 32'h0);
        n_cmp++;
        if ({fetch_bus.if_valid, pc} !== {1'b0, 32'h20}) begin
            n_fail++;
            $display("FAIL redir_flush: valid %b pc %h expected 0 00000020", fetch_bus.if_valid, pc);
        end
        tick();
        n_cmp++;
        if ({fetch_bus.if_valid, fetch_bus.if_pc, fetch_bus.if_instr} !== {1'b1, 32'h20, 32'h4020_A1B3}) begin
            n_fail++;
            $display("FAIL redir_target: valid %b pc %h instr %h expected 1 00000020 4020a1b3",
                     fetch_bus.if_valid, fetch_bus.if_pc, fetch_bus.if_instr);
        end
        tick();
        n_cmp++;
        if ({fetch_bus.if_valid, fetch_bus.if_pc, fetch_bus.if_instr} !== {1'b1, 32'h24, imem[9]}) begin
            n_fail++;
            $display("FAIL redir_next: valid %b pc %h instr %h expected 1 00000024 %h",
                     fetch_bus.if_valid, fetch_bus.if_pc, fetch_bus.if_instr, imem[9]);
        end
    endtask

    task automatic test_end_of_memory();
        apply_reset();
        drive(1'b1, 1'b1, 32'h68);
        tick();
        drive(1'b1, 1'b0, 32'h0);
        n_cmp++;
        if ({fetch_bus.if_valid, pc, state_dbg} !== {1'b0, 32'h68, RUN}) begin
            n_fail++;
            $display("FAIL eom_redirect: valid %b pc %h state %b expected 0 00000068 0", fetch_bus.if_valid, pc, state_dbg);
        end
        tick();
        n_cmp++;
        if ({fetch_bus.if_valid, fetch_bus.if_pc, fetch_bus.if_instr, fetch_done} !== {1'b1, 32'h68, 32'hFF00_F155, 1'b0}) begin
            n_fail++;
            $display("FAIL eom_beat0: valid %b pc %h instr %h done %b expected 1 00000068 ff00f155 0",
                     fetch_bus.if_valid, fetch_bus.if_pc, fetch_bus.if_instr, fetch_done);
        end
        tick();
        n_cmp++;
        if ({fetch_bus.if_valid, fetch_bus.if_pc, fetch_bus.if_instr, fetch_done, pc} !== {1'b1, 32'h6C, 32'h1000_F155, 1'b0, 32'h6C}) begin
            n_fail++;
            $display("FAIL eom_beat1: valid %b pc %h instr %h done %b fetch_pc %h expected 1 0000006c 1000f155 0 0000006c",
                     fetch_bus.if_valid, fetch_bus.if_pc, fetch_bus.if_instr, fetch_done, pc);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if ({fetch_bus.if_valid, fetch_done, pc, state_dbg} !== {1'b0, 1'b1, 32'h6C, HALT}) begin
                n_fail++;
                $display("FAIL eom_halted%0d: valid %b done %b pc %h state %b expected 0 1 0000006c 1",
                         c, fetch_bus.if_valid, fetch_done, pc, state_dbg);
            end
        end
    endtask

    task automatic test_misalign_range();
        apply_reset();
        drive(1'b1, 1'b1, 32'h22);
        tick();
        drive(1'b1, 1'b0, 32'h0);
        n_cmp++;
        if ({pc, misalign_err, fetch_bus.if_valid} !== {32'h20, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mis_redirect: pc %h err %b valid %b expected 00000020 1 0", pc, misalign_err, fetch_bus.if_valid);
        end
        tick();
        n_cmp++;
        if ({fetch_bus.if_valid, fetch_bus.if_pc, fetch_bus.if_instr} !== {1'b1, 32'h20, imem[8]}) begin
            n_fail++;
            $display("FAIL mis_fetch: valid %b pc %h instr %h expected 1 00000020 %h",
                     fetch_bus.if_valid, fetch_bus.if_pc, fetch_bus.if_instr, imem[8]);
        end
        drive(1'b1, 1'b1, 32'h40);
        tick();
        drive(1'b1, 1'b0, 32'h0);
        n_cmp++;
        if ({pc, misalign_err} !== {32'h40, 1'b1}) begin
            n_fail++;
            $display("FAIL mis_sticky: pc %h err %b expected 00000040 1", pc, misalign_err);
        end
        drive(1'b1, 1'b1, 32'h70);
        tick();
        drive(1'b1, 1'b0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if ({pc, state_dbg, fetch_done, fetch_bus.if_valid, misalign_err} !== {32'h70, HALT, 1'b1, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL range_halt%0d: pc %h state %b done %b valid %b err %b expected 00000070 1 1 0 1",
                         c, pc, state_dbg, fetch_done, fetch_bus.if_valid, misalign_err);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [99:0] got;
        logic [99:0] exp;
        apply_reset();
        drive(1'b0, 1'b1, 32'h6A);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        n_cmp++;
        if ({state_dbg, fetch_bus.if_valid, fetch_bus.if_pc, pc, misalign_err} !== {HALT, 1'b1, 32'h68, 32'h6C, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_setup: state %b valid %b head %h pc %h err %b expected 1 1 00000068 0000006c 1",
                     state_dbg, fetch_bus.if_valid, fetch_bus.if_pc, pc, misalign_err);
        end
        reset = 1'b1;
        tick();
        got = {pc, fetch_bus.if_valid, fetch_bus.if_instr, fetch_bus.if_pc, fetch_done, misalign_err, state_dbg};
        exp = {32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, RUN};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL mid_reset_values: got %h expected %h", got, exp);
        end
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h0);
        tick();
        n_cmp++;
        if ({fetch_bus.if_valid, fetch_bus.if_pc, fetch_bus.if_instr} !== {1'b1, 32'h0, W0}) begin
            n_fail++;
            $display("FAIL mid_restart: valid %b pc %h instr %h expected 1 0 %h",
                     fetch_bus.if_valid, fetch_bus.if_pc, fetch_bus.if_instr, W0);
        end
    endtask

    // Randomized run: the model tracks the fetch PC, a halted flag, the sticky
    // error and the queue contents as a list of {pc, instr} entries.
    task automatic test_random();
        logic [31:0] mpc;
        logic [31:0] rpc;
        logic        mhalt;
        logic        mmis;
        logic        rdy;
        logic        rv;
        logic        popping;
        logic        room;
        apply_reset();
        exp_q.delete();
        mpc   = 32'h0;
        mhalt = 1'b0;
        mmis  = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            n_cmp++;
            if (fetch_bus.if_valid !== (exp_q.size() > 0)) begin
                n_fail++;
                $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, fetch_bus.if_valid, exp_q.size() > 0);
            end
            if (exp_q.size() > 0) begin
                n_cmp++;
                if ({fetch_bus.if_pc, fetch_bus.if_instr} !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL rnd_head@%0d: got %h%h expected %h", cyc, fetch_bus.if_pc, fetch_bus.if_instr, exp_q[0]);
                end
            end
            n_cmp++;
            if ({pc, misalign_err, fetch_done} !== {mpc, mmis, mhalt && (exp_q.size() == 0)}) begin
                n_fail++;
                $display("FAIL rnd_state@%0d: pc %h err %b done %b expected %h %b %b",
                         cyc, pc, misalign_err, fetch_done, mpc, mmis, mhalt && (exp_q.size() == 0));
            end

            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            rpc = 32'($urandom_range(0, 31) * 4);
            if ($urandom_range(0, 3) == 0) rpc = rpc + 32'($urandom_range(1, 3));
            drive(rdy, rv, rpc);

            popping = (exp_q.size() > 0) && rdy;
            if (rv) begin
                exp_q.delete();
                mpc   = rpc & ~32'h3;
                mhalt = (mpc >= 32'(MEM_BYTES));
                if (rpc[1:0] != 2'b00) mmis = 1'b1;
            end else begin
                room = (exp_q.size() < DEPTH) || popping;
                if (popping) void'(exp_q.pop_front());
                if (!mhalt && room) begin
                    exp_q.push_back({mpc, imem[mpc / 4]});
                    if (mpc == 32'(MEM_BYTES - 4)) mhalt = 1'b1;
                    else mpc = mpc + 32'd4;
                end
            end
            tick();
        end
        drive(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < N_WORDS; i++) imem[i] = $urandom;
        imem[0]  = W0;
        imem[1]  = W1;
        imem[2]  = W2;
        imem[8]  = 32'h4020_A1B3;
        imem[26] = 32'hFF00_F155;
        imem[27] = 32'h1000_F155;
        drive(1'b0, 1'b0, 32'h0);

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_end_of_memory();
        test_misalign_range();
        test_reset_mid();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
